nv_nvdla_mcif_write_ig_arb: RTL and testbench
=============================================

Name: nv_nvdla_mcif_write_ig_arb

Overview:
Write-ingress scheduler for MCIF. Shares the single AXI AW issue slot between the five write DMA clients (0=bdma, 1=sdp, 2=pdp, 3=cdp, 4=rbk) using weighted round-robin. Pushes the per-request context {len, require_ack} into the write context queue. Throttles issue with an outstanding-beat counter that is credited back by the egress-side eg2ig_axi_vld/eg2ig_axi_len return.

Parameters:
NCLI, 5, number of write clients (client id = AXI id[2:0])
AW, 64, address width
OSW, 9, outstanding-beat counter width (holds up to 256 beats)

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- req_pvld  in  NCLI  per-client request valid
- req_prdy  out  NCLI  per-client request accept
- req_addr  in  NCLI*AW  per-client address, client i at [i*AW +: AW]
- req_len  in  NCLI*2  per-client burst length minus 1 (0..3 = 1..4 beats)
- req_require_ack  in  NCLI  per-client completion-required flag
- reg2dp_wr_os_cnt  in  8  maximum outstanding beats minus 1
- reg2dp_wr_weight  in  NCLI*8  per-client extra consecutive grants
- cq_wr_pvld  out  1  context-queue push valid
- cq_wr_prdy  in  1  context-queue push ready
- cq_wr_thread_id  out  3  target queue = winning client id
- cq_wr_pd  out  3  {len[1:0], require_ack}
- aw_pvld  out  1  AW command valid (registered)
- aw_prdy  in  1  AW command accept
- aw_id  out  3  AXI id
- aw_addr  out  AW  AXI address
- aw_len  out  2  AXI len
- eg2ig_axi_vld  in  1  egress write response returned
- eg2ig_axi_len  in  2  length minus 1 of the returned burst
- os_idle  out  1  no outstanding beats and AW stage empty
- os_err  out  1  sticky underflow/overflow error

Behaviour:
- Reset values: aw_pvld=0, aw_id/aw_addr/aw_len=0, os_err=0. State: ptr=NCLI-1, wcnt=0, os_cnt=0.
- Winner selection (combinational):
  - If req_pvld[ptr] and wcnt!=0, winner=ptr.
  - Otherwise the winner is the first requester scanning ptr+1, ptr+2, … modulo NCLI, with ptr itself checked last.
  - No winner when req_pvld==0.
- Credit check: ok = (os_cnt + winner_len + 1) <= (reg2dp_wr_os_cnt + 1).
  - Compare at OSW+1 bits.
  - Uses registered os_cnt; a same-cycle return is not counted (conservative).
- slot_free = !aw_pvld | aw_prdy.
- cq_wr_pvld = winner_exists & ok & slot_free. It must not depend on cq_wr_prdy.
- commit = cq_wr_pvld & cq_wr_prdy. Only req_prdy[winner] = commit; all other req_prdy bits are 0.
- A winner that fails the credit check blocks all clients; there is no skip-ahead to a shorter request (no starvation).
- On commit, registered on the next edge:
  - aw_pvld=1; aw_id/addr/len load from the winner.
  - os_cnt += winner_len + 1.
  - If winner==ptr: wcnt -= 1. Otherwise ptr=winner and wcnt=reg2dp_wr_weight[winner].
  - Net effect: weight k gives k+1 back-to-back grants.
- If aw_prdy & !commit: aw_pvld goes to 0.
- AW stage latency: request accept to aw_pvld is 1 cycle. Back-to-back issue is allowed when aw_prdy=1.
- Return path: eg2ig_axi_vld subtracts eg2ig_axi_len + 1 from os_cnt.
- Simultaneous commit and return: os_cnt_next = os_cnt + inc - dec in a single update.
- Underflow (dec > os_cnt + inc): os_cnt clamps to 0 and os_err=1.
- Overflow past the OSW range: os_err=1. os_err clears only on reset.
- os_idle = (os_cnt==0) & !aw_pvld.
- Weight or limit register changes take effect on the next selection. Lowering reg2dp_wr_os_cnt below the current os_cnt only stalls issue; it is not an error.
- Reset asserted mid-operation discards the outstanding count and all arbiter state immediately.

Decomposition:
- Package nv_nvdla_mcif_pkg holds the client id constants (BDMA=0, SDP=1, PDP=2, CDP=3, RBK=4), the cq pd field layout {len, require_ack}, and the AXI len width.
- One sub-module: nv_nvdla_mcif_wrr_arb, containing the ptr/wcnt state, winner scan and commit update.
- The credit counter and AW register stay in the top.

Test Plan:
- Single client 1 requests len=3, os_cnt=0, limit=255 → cq_wr_pd=3'b111 (with require_ack=1), thread_id=1; aw_pvld next cycle with aw_id=1, aw_len=3; os_cnt=4.
- All 5 clients request continuously, weights 0,2,0,0,0, aw_prdy=1 → grant order 0,1,1,1,2,3,4,0,…
- Limit=3 (4 beats), client 0 issues len=3 → os_cnt=4; next request stalls with cq_wr_pvld=0. eg2ig_axi_vld with len=3 → os_cnt=0 and issue resumes the following cycle.
- Commit len=1 in the same cycle as a return with len=0 from os_cnt=2 → os_cnt=3.
- aw_prdy=0 held with aw_pvld=1 → no new commit, req_prdy=0, AW fields stable; aw_prdy=1 → next commit lands the same edge.
- eg2ig_axi_vld len=2 while os_cnt=1 → os_cnt=0, os_err=1 and sticky until nvdla_core_rstn pulses low mid-stream, after which all outputs are at reset values.

Source files
------------

// File: rtl/nv_nvdla_mcif_pkg.sv
// Shared constants and field layouts for the MCIF write ingress path.
package nv_nvdla_mcif_pkg;

    localparam int CID_W     = 3;
    localparam int AXI_LEN_W = 2;
    localparam int CQ_PD_W   = AXI_LEN_W + 1;

    localparam logic [CID_W-1:0] CID_BDMA = 3'd0;
    localparam logic [CID_W-1:0] CID_SDP  = 3'd1;
    localparam logic [CID_W-1:0] CID_PDP  = 3'd2;
    localparam logic [CID_W-1:0] CID_CDP  = 3'd3;
    localparam logic [CID_W-1:0] CID_RBK  = 3'd4;

    typedef struct packed {
        logic [AXI_LEN_W-1:0] len;
        logic                 require_ack;
    } cq_pd_t;

endpackage

// File: rtl/nv_nvdla_mcif_wrr_arb.sv
// Weighted round-robin pick among write clients.
// A client keeps the grant for weight+1 consecutive commits while it requests.
module nv_nvdla_mcif_wrr_arb
    import nv_nvdla_mcif_pkg::*;
#(
    parameter int NCLI = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCLI-1:0]    req,
    input  logic [NCLI*8-1:0]  weight,
    input  logic               commit,
    output logic               win_vld,
    output logic [CID_W-1:0]   win
);

    logic [CID_W-1:0] ptr;
    logic [7:0]       wcnt;
    logic [CID_W:0]   pos;

    always_comb begin
        win_vld = |req;
        win     = ptr;
        pos     = '0;
        if (!(req[ptr] && wcnt != 8'd0)) begin
            // Descending scan so the nearest client after ptr wins; ptr is last.
            for (int i = NCLI; i >= 1; i--) begin
                pos = {1'b0, ptr} + (CID_W+1)'(i);
                if (pos >= (CID_W+1)'(NCLI)) pos = pos - (CID_W+1)'(NCLI);
                if (req[pos[CID_W-1:0]]) win = pos[CID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= CID_W'(NCLI - 1);
            wcnt <= '0;
        end else if (commit) begin
            if (win == ptr && wcnt != 8'd0) begin
                wcnt <= wcnt - 8'd1;
            end else begin
                ptr  <= win;
                wcnt <= weight[int'(win)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_mcif_write_ig_arb.sv
// MCIF write ingress: WRR client pick, context-queue push, AW register
// and outstanding-beat credit counter fed back from egress.
module nv_nvdla_mcif_write_ig_arb
    import nv_nvdla_mcif_pkg::*;
#(
    parameter int NCLI = 5,
    parameter int AW   = 64,
    parameter int OSW  = 9
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [NCLI-1:0]        req_pvld,
    output logic [NCLI-1:0]        req_prdy,
    input  logic [NCLI*AW-1:0]     req_addr,
    input  logic [NCLI*2-1:0]      req_len,
    input  logic [NCLI-1:0]        req_require_ack,
    input  logic [7:0]             reg2dp_wr_os_cnt,
    input  logic [NCLI*8-1:0]      reg2dp_wr_weight,
    output logic                   cq_wr_pvld,
    input  logic                   cq_wr_prdy,
    output logic [CID_W-1:0]       cq_wr_thread_id,
    output logic [CQ_PD_W-1:0]     cq_wr_pd,
    output logic                   aw_pvld,
    input  logic                   aw_prdy,
    output logic [CID_W-1:0]       aw_id,
    output logic [AW-1:0]          aw_addr,
    output logic [AXI_LEN_W-1:0]   aw_len,
    input  logic                   eg2ig_axi_vld,
    input  logic [AXI_LEN_W-1:0]   eg2ig_axi_len,
    output logic                   os_idle,
    output logic                   os_err
);

    localparam int CW = OSW + 1;

    logic                 win_vld;
    logic [CID_W-1:0]     win;
    logic [AXI_LEN_W-1:0] win_len;
    logic [AW-1:0]        win_addr;
    logic                 win_ack;
    logic                 ok;
    logic                 slot_free;
    logic                 commit;
    logic [OSW-1:0]       os_cnt;
    logic [CW-1:0]        inc;
    logic [CW-1:0]        dec;
    logic [CW-1:0]        sum;
    logic [CW-1:0]        nxt;
    logic                 under;
    logic                 over;
    cq_pd_t               pd;

    nv_nvdla_mcif_wrr_arb #(.NCLI(NCLI)) u_arb (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .req     (req_pvld),
        .weight  (reg2dp_wr_weight),
        .commit  (commit),
        .win_vld (win_vld),
        .win     (win)
    );

    assign win_len  = req_len[{win, 1'b0} +: AXI_LEN_W];
    assign win_addr = req_addr[int'(win)*AW +: AW];
    assign win_ack  = req_require_ack[win];

    // Credit check uses the registered count only; same-cycle returns wait.
    assign ok = ({1'b0, os_cnt} + CW'(win_len) + CW'(1))
             <= (CW'(reg2dp_wr_os_cnt) + CW'(1));

    assign slot_free  = !aw_pvld | aw_prdy;
    assign cq_wr_pvld = win_vld & ok & slot_free;
    assign commit     = cq_wr_pvld & cq_wr_prdy;
    assign req_prdy   = commit ? (NCLI'(1) << win) : '0;

    assign pd.len          = win_len;
    assign pd.require_ack  = win_ack;
    assign cq_wr_pd        = pd;
    assign cq_wr_thread_id = win;

    assign inc   = commit ? CW'(win_len) + CW'(1) : '0;
    assign dec   = eg2ig_axi_vld ? CW'(eg2ig_axi_len) + CW'(1) : '0;
    assign sum   = {1'b0, os_cnt} + inc;
    assign under = dec > sum;
    assign nxt   = sum - dec;
    assign over  = !under & nxt[OSW];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            os_cnt <= '0;
            os_err <= 1'b0;
        end else begin
            if (under)     os_cnt <= '0;
            else if (over) os_cnt <= '1;
            else           os_cnt <= nxt[OSW-1:0];
            if (under | over) os_err <= 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            aw_pvld <= 1'b0;
            aw_id   <= '0;
            aw_addr <= '0;
            aw_len  <= '0;
        end else if (commit) begin
            aw_pvld <= 1'b1;
            aw_id   <= win;
            aw_addr <= win_addr;
            aw_len  <= win_len;
        end else if (aw_prdy) begin
            aw_pvld <= 1'b0;
        end
    end

    assign os_idle = (os_cnt == '0) & !aw_pvld;

endmodule

// File: tb/tb_nv_nvdla_mcif_write_ig_arb.sv
// Directed bench: WRR order table plus credit, stall, error and
// reset sequences for the MCIF write ingress arbiter.
module tb_nv_nvdla_mcif_write_ig_arb;

    localparam int NCLI = 5;
    localparam int AW   = 64;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NCLI-1:0]      req_pvld = '0;
    logic [NCLI-1:0]      req_prdy;
    logic [NCLI*AW-1:0]   req_addr = '0;
    logic [NCLI*2-1:0]    req_len = '0;
    logic [NCLI-1:0]      req_require_ack = '0;
    logic [7:0]           wr_os_cnt = 8'd255;
    logic [NCLI*8-1:0]    wr_weight = '0;
    logic                 cq_wr_pvld;
    logic                 cq_wr_prdy = 1'b1;
    logic [2:0]           cq_wr_thread_id;
    logic [2:0]           cq_wr_pd;
    logic                 aw_pvld;
    logic                 aw_prdy = 1'b1;
    logic [2:0]           aw_id;
    logic [AW-1:0]        aw_addr;
    logic [1:0]           aw_len;
    logic                 eg_vld = 1'b0;
    logic [1:0]           eg_len = '0;
    logic                 os_idle;
    logic                 os_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_ig_arb dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .req_pvld         (req_pvld),
        .req_prdy         (req_prdy),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_require_ack  (req_require_ack),
        .reg2dp_wr_os_cnt (wr_os_cnt),
        .reg2dp_wr_weight (wr_weight),
        .cq_wr_pvld       (cq_wr_pvld),
        .cq_wr_prdy       (cq_wr_prdy),
        .cq_wr_thread_id  (cq_wr_thread_id),
        .cq_wr_pd         (cq_wr_pd),
        .aw_pvld          (aw_pvld),
        .aw_prdy          (aw_prdy),
        .aw_id            (aw_id),
        .aw_addr          (aw_addr),
        .aw_len           (aw_len),
        .eg2ig_axi_vld    (eg_vld),
        .eg2ig_axi_len    (eg_len),
        .os_idle          (os_idle),
        .os_err           (os_err)
    );

    typedef struct {
        logic [4:0] req;
        logic       cq_rdy;
        logic       exp_vld;
        logic [2:0] exp_tid;
        logic [4:0] exp_prdy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] caddr(input int i);
        return 64'hA000_0000_0000_0040 | (64'(i) << 8);
    endfunction

    task automatic set_len(input int i, input logic [1:0] v);
        req_len[i*2 +: 2] = v;
    endtask

    initial begin
        for (int i = 0; i < NCLI; i++) req_addr[i*AW +: AW] = caddr(i);

        // WRR order with weights 0,2,0,0,0 starting from reset pointer 4
        tbl[0]  = '{5'b11111, 1'b1, 1'b1, 3'd0, 5'b00001};
        tbl[1]  = '{5'b11111, 1'b1, 1'b1, 3'd1, 5'b00010};
        tbl[2]  = '{5'b11111, 1'b0, 1'b1, 3'd1, 5'b00000};
        tbl[3]  = '{5'b11111, 1'b1, 1'b1, 3'd1, 5'b00010};
        tbl[4]  = '{5'b11111, 1'b1, 1'b1, 3'd1, 5'b00010};
        tbl[5]  = '{5'b11111, 1'b1, 1'b1, 3'd2, 5'b00100};
        tbl[6]  = '{5'b11001, 1'b1, 1'b1, 3'd3, 5'b01000};
        tbl[7]  = '{5'b00010, 1'b1, 1'b1, 3'd1, 5'b00010};
        tbl[8]  = '{5'b00100, 1'b1, 1'b1, 3'd2, 5'b00100};
        tbl[9]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000};
        tbl[10] = '{5'b11111, 1'b1, 1'b1, 3'd3, 5'b01000};
        tbl[11] = '{5'b11111, 1'b1, 1'b1, 3'd4, 5'b10000};
        tbl[12] = '{5'b11111, 1'b1, 1'b1, 3'd0, 5'b00001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_aw_pvld", aw_pvld, 0);
        chk("rst_aw_id", aw_id, 0);
        chk("rst_aw_addr", aw_addr, 0);
        chk("rst_aw_len", aw_len, 0);
        chk("rst_os_err", os_err, 0);
        chk("rst_os_idle", os_idle, 1);
        chk("rst_cq_vld", cq_wr_pvld, 0);
        rstn = 1'b1;
        cyc();

        wr_weight = 40'h00_00_00_02_00;
        for (int i = 0; i < 13; i++) begin
            req_pvld   = tbl[i].req;
            cq_wr_prdy = tbl[i].cq_rdy;
            #1;
            chk($sformatf("wrr%0d_vld", i), cq_wr_pvld, tbl[i].exp_vld);
            if (tbl[i].exp_vld)
                chk($sformatf("wrr%0d_tid", i), cq_wr_thread_id, tbl[i].exp_tid);
            chk($sformatf("wrr%0d_prdy", i), req_prdy, tbl[i].exp_prdy);
            cyc();
            chk($sformatf("wrr%0d_awv", i), aw_pvld,
                tbl[i].exp_vld & tbl[i].cq_rdy);
            if (tbl[i].exp_vld & tbl[i].cq_rdy)
                chk($sformatf("wrr%0d_awid", i), aw_id, tbl[i].exp_tid);
        end
        chk("wrr_os_cnt", dut.os_cnt, 11);

        // reset asserted while AW is pending and beats are outstanding
        cq_wr_prdy = 1'b1;
        req_pvld   = '0;
        rstn       = 1'b0;
        #1;
        chk("mid_rst_awv", aw_pvld, 0);
        chk("mid_rst_os", dut.os_cnt, 0);
        chk("mid_rst_idle", os_idle, 1);
        cyc();
        rstn = 1'b1;
        wr_weight = '0;
        cyc();

        // single client 1, len 3, require_ack
        set_len(1, 2'd3);
        req_require_ack = 5'b00010;
        req_pvld = 5'b00010;
        #1;
        chk("t1_vld", cq_wr_pvld, 1);
        chk("t1_tid", cq_wr_thread_id, 1);
        chk("t1_pd", cq_wr_pd, 3'b111);
        chk("t1_prdy", req_prdy, 5'b00010);
        cyc();
        req_pvld = '0;
        chk("t1_awv", aw_pvld, 1);
        chk("t1_awid", aw_id, 1);
        chk("t1_awlen", aw_len, 3);
        chk("t1_awaddr", aw_addr, caddr(1));
        chk("t1_os", dut.os_cnt, 4);
        chk("t1_idle", os_idle, 0);
        eg_vld = 1'b1;
        eg_len = 2'd3;
        cyc();
        eg_vld = 1'b0;
        chk("t1_ret_os", dut.os_cnt, 0);
        chk("t1_ret_idle", os_idle, 1);

        // credit limit of 4 beats
        wr_os_cnt = 8'd3;
        set_len(0, 2'd3);
        req_require_ack = '0;
        req_pvld = 5'b00001;
        #1;
        chk("cr_vld0", cq_wr_pvld, 1);
        chk("cr_prdy0", req_prdy, 5'b00001);
        cyc();
        chk("cr_os", dut.os_cnt, 4);
        chk("cr_stall_vld", cq_wr_pvld, 0);
        chk("cr_stall_prdy", req_prdy, 0);
        cyc();
        chk("cr_stall_vld2", cq_wr_pvld, 0);
        eg_vld = 1'b1;
        eg_len = 2'd3;
        #1;
        chk("cr_same_cyc", cq_wr_pvld, 0);
        cyc();
        eg_vld = 1'b0;
        chk("cr_ret_os", dut.os_cnt, 0);
        chk("cr_resume", cq_wr_pvld, 1);
        cyc();
        req_pvld = '0;
        chk("cr_os2", dut.os_cnt, 4);
        wr_os_cnt = 8'd255;
        eg_vld = 1'b1;
        eg_len = 2'd1;
        cyc();
        eg_vld = 1'b0;
        chk("cr_os3", dut.os_cnt, 2);

        // commit len 1 with a same-cycle return of len 0
        set_len(2, 2'd1);
        req_pvld = 5'b00100;
        eg_vld = 1'b1;
        eg_len = 2'd0;
        #1;
        chk("sim_vld", cq_wr_pvld, 1);
        cyc();
        req_pvld = '0;
        eg_vld = 1'b0;
        chk("sim_os", dut.os_cnt, 3);
        chk("sim_awid", aw_id, 2);

        // AW backpressure holds the stage
        aw_prdy = 1'b0;
        set_len(3, 2'd0);
        req_pvld = 5'b01000;
        #1;
        chk("bp_vld", cq_wr_pvld, 0);
        chk("bp_prdy", req_prdy, 0);
        cyc();
        chk("bp_awv", aw_pvld, 1);
        chk("bp_awid", aw_id, 2);
        chk("bp_awlen", aw_len, 1);
        chk("bp_awaddr", aw_addr, caddr(2));
        cyc();
        chk("bp_awid2", aw_id, 2);
        aw_prdy = 1'b1;
        #1;
        chk("bp_rel_vld", cq_wr_pvld, 1);
        chk("bp_rel_prdy", req_prdy, 5'b01000);
        cyc();
        req_pvld = '0;
        chk("bp_awv2", aw_pvld, 1);
        chk("bp_awid3", aw_id, 3);
        chk("bp_awlen2", aw_len, 0);
        chk("bp_os", dut.os_cnt, 4);

        // underflow is sticky until reset
        eg_vld = 1'b1;
        eg_len = 2'd3;
        cyc();
        eg_vld = 1'b0;
        chk("uf_os0", dut.os_cnt, 0);
        req_pvld = 5'b10000;
        cyc();
        req_pvld = '0;
        chk("uf_os1", dut.os_cnt, 1);
        eg_vld = 1'b1;
        eg_len = 2'd2;
        cyc();
        eg_vld = 1'b0;
        chk("uf_os", dut.os_cnt, 0);
        chk("uf_err", os_err, 1);
        chk("uf_idle", os_idle, 1);
        repeat (3) cyc();
        chk("uf_sticky", os_err, 1);
        req_pvld = 5'b00001;
        cyc();
        req_pvld = '0;
        chk("uf_awv", aw_pvld, 1);
        rstn = 1'b0;
        #1;
        chk("fin_awv", aw_pvld, 0);
        chk("fin_awid", aw_id, 0);
        chk("fin_awaddr", aw_addr, 0);
        chk("fin_awlen", aw_len, 0);
        chk("fin_err", os_err, 0);
        chk("fin_idle", os_idle, 1);
        cyc();
        rstn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
